// File: rtl/spi_master_sched.sv
// spi_master_sched
//   Master-side transfer scheduler for the Hamming-protected SPI link. Several local
//   requesters share one 16-bit-frame SPI bus through a round-robin arbiter. For each
//   granted request it asserts one slave select, shifts the encoded packet out MSB-first,
//   and captures the 16-bit reply. If the external decoder reports a double error, the
//   frame is repeated up to MAX_RETRY times. An idle gap follows every completed request.
//
// Ports
//   i_clk_in         system/SPI clock, all logic on the rising edge
//   i_reset          synchronous active-high reset
//   i_req            per-channel transfer request (level)
//   i_tx_packet      encoded packets, channel i in bits [16i+15:16i]
//   o_grant          one-hot single-cycle pulse: request accepted, packet latched
//   o_busy           high whenever the scheduler is not idle
//   o_ss             one-hot active-high slave select, high only while shifting
//   o_mosi           serial data to the slaves (low outside a frame)
//   i_miso           serial data from the selected slave
//   o_rx_packet      last received packet, also feeds the external decoder
//   i_rx_double_err  decoder double-error flag, sampled in the check cycle
//   o_rx_valid       single-cycle pulse: rx_packet / rx_chan / fail are final
//   o_rx_chan        channel of the completed request
//   o_fail           with o_rx_valid: retries exhausted, packet still corrupt

module spi_master_sched #(
  parameter int unsigned N_CHAN     = 4,
  parameter int unsigned MAX_RETRY  = 2,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                      i_clk_in,
  input  logic                      i_reset,
  input  logic [N_CHAN-1:0]         i_req,
  input  logic [16*N_CHAN-1:0]      i_tx_packet,
  output logic [N_CHAN-1:0]         o_grant,
  output logic                      o_busy,
  output logic [N_CHAN-1:0]         o_ss,
  output logic                      o_mosi,
  input  logic                      i_miso,
  output logic [15:0]               o_rx_packet,
  input  logic                      i_rx_double_err,
  output logic                      o_rx_valid,
  output logic [$clog2(N_CHAN)-1:0] o_rx_chan,
  output logic                      o_fail
);

  localparam int unsigned ChanW = $clog2(N_CHAN);
  localparam logic [2:0] LpMaxRetry = 3'(MAX_RETRY);
  // GAP_CYCLES == 0 bypasses the gap state entirely, so this value is then unused.
  localparam logic [3:0] LpGapLast  = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StCheck,
    StGap
  } state_t;

  state_t             r_state;
  logic [ChanW-1:0]   r_chan;
  logic [ChanW-1:0]   r_last;
  logic [2:0]         r_retry;
  logic [3:0]         r_cnt;
  logic [3:0]         r_gap;
  logic [15:0]        r_tx_hold;
  logic [15:0]        r_tx_sr;
  // Only 15 bits are kept: the 16th bit is taken straight from i_miso on the last edge.
  logic [14:0]        r_rx_sr;
  logic [15:0]        r_rx_packet;
  logic [ChanW-1:0]   r_rx_chan;
  logic               r_rx_valid;
  logic               r_fail;
  logic [N_CHAN-1:0]  r_ss;

  logic               w_found;
  logic [ChanW-1:0]   w_winner;
  int                 w_idx;
  logic               w_take;
  logic [N_CHAN-1:0]  w_grant;
  logic [N_CHAN-1:0]  w_chan_oh;
  logic [15:0]        w_tx_arr [N_CHAN];

  for (genvar g = 0; g < int'(N_CHAN); g++) begin : g_tx_slice
    assign w_tx_arr[g] = i_tx_packet[16*g +: 16];
  end

  // Round-robin search: first requester at or after r_last+1, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int i = 0; i < int'(N_CHAN); i++) begin
      w_idx = (int'(r_last) + 1 + i) % int'(N_CHAN);
      if (!w_found && i_req[w_idx[ChanW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[ChanW-1:0];
      end
    end
  end

  // The grant is issued in the same cycle the request is seen in idle; it is masked
  // during reset so no pulse escapes while the state is being cleared.
  assign w_take    = (r_state == StIdle) && w_found && !i_reset;
  assign w_grant   = w_take ? (N_CHAN'(1) << w_winner) : '0;
  assign w_chan_oh = N_CHAN'(1) << r_chan;

  always_ff @(posedge i_clk_in) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_chan      <= '0;
      r_last      <= ChanW'(N_CHAN - 1);
      r_retry     <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_tx_hold   <= '0;
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_rx_packet <= '0;
      r_rx_chan   <= '0;
      r_rx_valid  <= 1'b0;
      r_fail      <= 1'b0;
      r_ss        <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      r_fail     <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_take) begin
            r_chan    <= w_winner;
            r_tx_hold <= w_tx_arr[w_winner];
            r_tx_sr   <= w_tx_arr[w_winner];
            r_retry   <= '0;
            r_cnt     <= '0;
            r_ss      <= w_grant;
            r_state   <= StXfer;
          end
        end
        StXfer: begin
          r_tx_sr <= r_tx_sr << 1;
          r_rx_sr <= {r_rx_sr[13:0], i_miso};
          r_cnt   <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_rx_packet <= {r_rx_sr, i_miso};
            r_ss        <= '0;
            r_state     <= StCheck;
          end
        end
        StCheck: begin
          if (i_rx_double_err && (r_retry < LpMaxRetry)) begin
            // Replay the original packet; tx_sr was consumed by the previous frame.
            r_retry <= r_retry + 3'd1;
            r_tx_sr <= r_tx_hold;
            r_cnt   <= '0;
            r_ss    <= w_chan_oh;
            r_state <= StXfer;
          end else begin
            r_rx_valid <= 1'b1;
            r_rx_chan  <= r_chan;
            r_fail     <= i_rx_double_err;
            r_last     <= r_chan;
            r_gap      <= '0;
            r_state    <= (GAP_CYCLES == 0) ? StIdle : StGap;
          end
        end
        StGap: begin
          if (r_gap == LpGapLast) begin
            r_state <= StIdle;
          end else begin
            r_gap <= r_gap + 4'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_grant     = w_grant;
  assign o_busy      = (r_state != StIdle);
  assign o_ss        = r_ss;
  // Gated by state so the line rests low outside a frame regardless of tx_sr contents.
  assign o_mosi      = (r_state == StXfer) && r_tx_sr[15];
  assign o_rx_packet = r_rx_packet;
  assign o_rx_valid  = r_rx_valid;
  assign o_rx_chan   = r_rx_chan;
  assign o_fail      = r_fail;

endmodule
